jtpang_objdma: RTL and testbench
================================

# jtpang_objdma

Object-table DMA controller for the Pang video board. Once per frame, at the start of vertical blank, it copies the object table from the upper half of the shared char VRAM into the object engine's private buffer. During blank it borrows the VRAM scan port from the char tile scanner and returns it before active video. The CPU never stalls; the copy only consumes char scan time that is unused during blank.

## Interface
Parameters:
- AW, 8: log2 of bytes copied (2^AW = 256 bytes = 64 objects × 4 bytes).
- BASE, 13'h1000: VRAM byte address of object entry 0 (upper half).

Ports:
- rst  in  1  reset, asynchronous, active-high
- clk  in  1  video clock; scan RAM port clock
- lvbl  in  1  low during vertical blank
- dma_en  in  1  CPU register bit: auto-copy every frame
- dma_req  in  1  single-cycle CPU pulse: request one copy
- char_addr  in  13  char scanner's VRAM scan address
- vram_addr  out  13  address to VRAM scan port
- vram_q  in  8  VRAM scan data; registered, valid 1 clk after address
- obj_we  out  1  object buffer write strobe
- obj_addr  out  AW  object buffer byte address
- obj_din  out  8  object buffer write data
- busy  out  1  DMA owns the VRAM scan port
- done  out  1  1-clk pulse when a copy completes
- abort  out  1  sticky: last copy was cut by end of blank; cleared at next start

## Operation
- States: IDLE, ARMED, RUN, FLUSH.
- IDLE -> ARMED on dma_req. A dma_req during ARMED/RUN/FLUSH is latched and serviced in the next blank; one pending request at most.
- Trigger: falling edge of lvbl (lvbl registered, previous 1, current 0), taken when ARMED or dma_en=1 -> RUN, cnt=0, abort=0. If neither holds, stay put.
- RUN: vram_addr = BASE + cnt; cnt increments every clk. After issuing cnt = 2^AW-1 -> FLUSH.
- FLUSH: one clk for the last data beat, then done=1 -> IDLE (or ARMED if a request is pending).
- Write pipeline: a delayed copy of the address/valid drives obj_we=1, obj_addr=cnt_d, obj_din=vram_q, one clk after each issued address. The data is copied unchanged.
- Port mux: vram_addr = busy ? BASE+cnt : char_addr. busy=1 in RUN and FLUSH only.
- Blank ends (lvbl rises) in RUN: stop issuing, set abort=1, finish the in-flight write, go to IDLE. No done pulse and no re-arm. Buffer contents beyond the last written byte are stale.
- cnt is AW bits. It never wraps, because the RUN->FLUSH transition happens at the terminal count.
- Reset at any point: state IDLE, pending request cleared, no writes. A copy in progress is abandoned.

## Timing
- Reset values: vram_addr=char_addr (combinational mux), obj_we=0, obj_addr=0, obj_din=0, busy=0, done=0, abort=0.
- Start latency: busy rises 1 clk after the clk in which registered lvbl shows the falling edge.
- Throughput: 1 byte/clk. A full copy takes 2^AW+1 clks from busy rising to done (257 for AW=8).
- Writes: the first obj_we comes 1 clk after busy rises; the last comes in the FLUSH cycle. done is asserted the clk after FLUSH, with busy=0.
- dma_req and the lvbl edge in the same clk: the copy starts in this blank and the request is consumed.

## Structure
- Shared package jtpang_pkg: BASE default, object size (4 bytes), object count, and state encoding constants.
- Single module. No sub-module is needed; the counter/pipeline register stays inline.

## Test plan
- dma_en=1, VRAM[0x1000+i]=i^0x5A, lvbl falls -> 256 obj_we pulses, obj_addr 0..255, data i^0x5A, done exactly 257 clks after busy rises.
- dma_en=0, no request, lvbl falls -> busy stays 0 and vram_addr tracks char_addr with char_addr=0x0123.
- dma_req pulse during active video, dma_en=0 -> no activity until the next lvbl fall, then exactly one copy; the following frame does no copy.
- lvbl rises 100 clks into RUN -> 100 writes (obj_addr 0..99), abort=1, no done; the next full copy clears abort.
- dma_req in the same clk as the lvbl fall -> the copy runs in this blank, with no extra copy next frame.
- rst asserted at cnt=50 -> busy=0 and obj_we=0 immediately; after release with dma_en=1, the next blank copies all 256 bytes.

Source files
------------

// File: rtl/jtpang_pkg.sv
// jtpang_pkg: shared constants for the Pang object-table DMA.
//   OBJ_BASE   - VRAM byte address of object entry 0 (upper half of char VRAM)
//   OBJ_BYTES  - bytes per object entry
//   OBJ_COUNT  - number of object entries in the table
//   ST_*       - DMA controller state encoding
//   objdma_ctl_t - controller state record (FSM state + pending request),
//                  kept as one struct so checkers can bind to a single signal
package jtpang_pkg;

    localparam logic [12:0] OBJ_BASE  = 13'h1000;
    localparam int          OBJ_BYTES = 4;
    localparam int          OBJ_COUNT = 64;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_FLUSH = 2'd3;

    typedef struct packed {
        logic [1:0] state;
        logic       pend;   // one CPU request waiting for the next blank
    } objdma_ctl_t;

endpackage

// File: rtl/jtpang_objdma.sv
// jtpang_objdma: once-per-frame copy of the object table from char VRAM into
// the object engine's private buffer, using char scan bandwidth that is idle
// during vertical blank.
//
// Ports:
//   rst        in   async active-high reset
//   clk        in   video clock, also the VRAM scan port clock
//   lvbl       in   low during vertical blank
//   dma_en     in   auto-copy every frame
//   dma_req    in   single-cycle request for one copy
//   char_addr  in   char scanner's scan address (passed through when idle)
//   vram_addr  out  VRAM scan port address
//   vram_q     in   VRAM scan data, valid one clk after the address
//   obj_we     out  object buffer write strobe
//   obj_addr   out  object buffer byte address
//   obj_din    out  object buffer write data
//   busy       out  DMA owns the VRAM scan port (RUN/FLUSH)
//   done       out  one-clk pulse when a full copy completes
//   abort      out  sticky: last copy was cut short by the end of blank
//
// Write interface contract: obj_we acts as a valid strobe with no ready; the
// object buffer accepts obj_addr/obj_din in every cycle obj_we is high, and
// obj_addr/obj_din carry no meaning while obj_we is low.
module jtpang_objdma
    import jtpang_pkg::*;
#(
    parameter int          AW   = $clog2(OBJ_BYTES * OBJ_COUNT),
    parameter logic [12:0] BASE = OBJ_BASE
)(
    input  logic          rst,
    input  logic          clk,
    input  logic          lvbl,
    input  logic          dma_en,
    input  logic          dma_req,
    input  logic [12:0]   char_addr,
    output logic [12:0]   vram_addr,
    input  logic [7:0]    vram_q,
    output logic          obj_we,
    output logic [AW-1:0] obj_addr,
    output logic [7:0]    obj_din,
    output logic          busy,
    output logic          done,
    output logic          abort
);

    logic          lvbl_d1, lvbl_d2;
    logic          blank_fall, blank_rise;
    logic          start;
    objdma_ctl_t   ctl;
    logic [AW-1:0] cnt;
    logic [AW-1:0] cnt_d;
    logic          iss_v;

    // Edges are taken on the registered lvbl so the trigger never depends on
    // the raw timing of the video counter output.
    assign blank_fall = lvbl_d2 & ~lvbl_d1;
    assign blank_rise = ~lvbl_d2 & lvbl_d1;

    // A request arriving in the same clk as the edge is honoured in this blank.
    assign start = blank_fall && ((ctl.state == ST_ARMED) || dma_en || dma_req);

    assign busy      = (ctl.state == ST_RUN) || (ctl.state == ST_FLUSH);
    assign vram_addr = busy ? BASE + 13'(cnt) : char_addr;

    // vram_q is registered by the RAM, so it lines up with the delayed valid.
    assign obj_we   = iss_v;
    assign obj_addr = cnt_d;
    assign obj_din  = iss_v ? vram_q : 8'd0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lvbl_d1   <= 1'b0;
            lvbl_d2   <= 1'b0;
            ctl.state <= ST_IDLE;
            ctl.pend  <= 1'b0;
            cnt       <= '0;
            cnt_d     <= '0;
            iss_v     <= 1'b0;
            done      <= 1'b0;
            abort     <= 1'b0;
        end else begin
            lvbl_d1 <= lvbl;
            lvbl_d2 <= lvbl_d1;
            done    <= 1'b0;
            iss_v   <= 1'b0;

            case (ctl.state)
                ST_IDLE, ST_ARMED: begin
                    if (start) begin
                        ctl.state <= ST_RUN;
                        cnt       <= '0;
                        abort     <= 1'b0;
                        // Already armed: a fresh request is for the next blank.
                        if (ctl.state == ST_ARMED && dma_req)
                            ctl.pend <= 1'b1;
                    end else if (dma_req) begin
                        if (ctl.state == ST_IDLE)
                            ctl.state <= ST_ARMED;
                        else
                            ctl.pend <= 1'b1;
                    end
                end

                ST_RUN: begin
                    if (dma_req)
                        ctl.pend <= 1'b1;
                    if (blank_rise) begin
                        // Stop issuing; the write for the previous address is
                        // already in the pipeline and completes this cycle.
                        ctl.state <= ST_IDLE;
                        ctl.pend  <= 1'b0;
                        abort     <= 1'b1;
                    end else begin
                        iss_v <= 1'b1;
                        cnt_d <= cnt;
                        // Leave the counter at its terminal value so it never
                        // wraps; FLUSH only drains the last data beat.
                        if (&cnt)
                            ctl.state <= ST_FLUSH;
                        else
                            cnt <= cnt + 1'b1;
                    end
                end

                ST_FLUSH: begin
                    done      <= 1'b1;
                    ctl.pend  <= 1'b0;
                    ctl.state <= (ctl.pend || dma_req) ? ST_ARMED : ST_IDLE;
                end

                default: begin
                    ctl.state <= ST_IDLE;
                    ctl.pend  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jtpang_objdma.sv
// tb_jtpang_objdma: directed bench for jtpang_objdma with a registered VRAM
// model, a write scoreboard fed from an expected queue, and one summary line.
module tb_jtpang_objdma;

    logic        rst;
    logic        clk;
    logic        lvbl;
    logic        dma_en;
    logic        dma_req;
    logic [12:0] char_addr;
    logic [12:0] vram_addr;
    logic [7:0]  vram_q;
    logic        obj_we;
    logic [7:0]  obj_addr;
    logic [7:0]  obj_din;
    logic        busy;
    logic        done;
    logic        abort;

    logic [7:0]  vram [0:8191];
    logic [15:0] exp_q[$];
    int          n_cmp;
    int          n_err;
    int          wr_cnt;

    jtpang_objdma dut (
        .rst       (rst),
        .clk       (clk),
        .lvbl      (lvbl),
        .dma_en    (dma_en),
        .dma_req   (dma_req),
        .char_addr (char_addr),
        .vram_addr (vram_addr),
        .vram_q    (vram_q),
        .obj_we    (obj_we),
        .obj_addr  (obj_addr),
        .obj_din   (obj_din),
        .busy      (busy),
        .done      (done),
        .abort     (abort)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered scan port: data for an address appears one clk later.
    always @(posedge clk) vram_q <= vram[vram_addr];

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1, "timeout");
    end

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every write must match the head of the expected queue.
    always @(negedge clk) begin
        if (obj_we === 1'b1) begin
            wr_cnt++;
            n_cmp++;
            assert (exp_q.size() != 0) else begin
                n_err++;
                $error("FAIL unexpected_write: observed addr %0h data %0h expected no write", obj_addr, obj_din);
            end
            if (exp_q.size() != 0)
                chk("write", {16'd0, obj_addr, obj_din}, {16'd0, exp_q.pop_front()});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_copy(input int n);
        logic [7:0] a;
        for (int i = 0; i < n; i++) begin
            a = 8'(i);
            exp_q.push_back({a, a ^ 8'h5A});
        end
    endtask

    task automatic wait_busy(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy !== 1'b1 && n < 20);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done !== 1'b1 && n < 400);
    endtask

    task automatic watch(input int cycles, output int busy_n, output int done_n);
        busy_n = 0;
        done_n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (busy === 1'b1) busy_n++;
            if (done === 1'b1) done_n++;
        end
    endtask

    task automatic full_copy(input string tag, input int exp_latency);
        int n;
        wr_cnt = 0;
        push_copy(256);
        lvbl = 1'b0;
        wait_busy(n);
        chk({tag, "_start_latency"}, n, exp_latency);
        wait_done(n);
        chk({tag, "_done_latency"}, n, 257);
        chk({tag, "_busy_at_done"}, busy, 0);
        chk({tag, "_write_count"}, wr_cnt, 256);
        chk({tag, "_queue_empty"}, exp_q.size(), 0);
        @(negedge clk);
        chk({tag, "_done_one_clk"}, done, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n, bn, dn;
        n_cmp = 0;
        n_err = 0;
        wr_cnt = 0;
        vram_q = 8'd0;
        for (int i = 0; i < 8192; i++) vram[i] = 8'(i * 7 + 3);
        for (int i = 0; i < 256; i++) vram[13'h1000 + i] = 8'(i) ^ 8'h5A;

        rst = 1'b1;
        lvbl = 1'b1;
        dma_en = 1'b0;
        dma_req = 1'b0;
        char_addr = 13'h0123;
        repeat (3) @(negedge clk);

        // reset state
        chk("rst_vram_addr", vram_addr, 13'h0123);
        chk("rst_obj_we", obj_we, 0);
        chk("rst_obj_addr", obj_addr, 0);
        chk("rst_obj_din", obj_din, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_abort", abort, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // 1: auto copy
        dma_en = 1'b1;
        full_copy("t1", 2);
        lvbl = 1'b1;
        dma_en = 1'b0;
        repeat (10) @(negedge clk);

        // 2: disabled, no request -> scan port stays with the char scanner
        lvbl = 1'b0;
        watch(40, bn, dn);
        chk("t2_busy_cycles", bn, 0);
        chk("t2_vram_addr", vram_addr, 13'h0123);
        char_addr = 13'h1ABC;
        #1;
        chk("t2_vram_addr_track", vram_addr, 13'h1ABC);
        char_addr = 13'h0123;
        lvbl = 1'b1;
        repeat (10) @(negedge clk);

        // 3: request during active video -> one copy next blank only
        dma_req = 1'b1;
        @(negedge clk);
        dma_req = 1'b0;
        watch(20, bn, dn);
        chk("t3_idle_before_blank", bn, 0);
        full_copy("t3", 2);
        lvbl = 1'b1;
        repeat (10) @(negedge clk);
        lvbl = 1'b0;
        watch(300, bn, dn);
        chk("t3_no_second_copy", bn, 0);
        chk("t3_no_second_done", dn, 0);
        lvbl = 1'b1;
        repeat (10) @(negedge clk);

        // 4: blank ends 100 clks into RUN -> 100 writes, abort, no done
        dma_en = 1'b1;
        wr_cnt = 0;
        push_copy(100);
        lvbl = 1'b0;
        wait_busy(n);
        chk("t4_start_latency", n, 2);
        repeat (99) @(negedge clk);
        lvbl = 1'b1;
        watch(30, bn, dn);
        chk("t4_no_done", dn, 0);
        chk("t4_busy_released", busy, 0);
        chk("t4_abort", abort, 1);
        chk("t4_write_count", wr_cnt, 100);
        chk("t4_queue_empty", exp_q.size(), 0);
        wr_cnt = 0;
        push_copy(256);
        lvbl = 1'b0;
        wait_busy(n);
        chk("t4_abort_cleared_at_start", abort, 0);
        wait_done(n);
        chk("t4_recopy_done_latency", n, 257);
        chk("t4_recopy_write_count", wr_cnt, 256);
        chk("t4_recopy_abort", abort, 0);
        lvbl = 1'b1;
        dma_en = 1'b0;
        repeat (10) @(negedge clk);

        // 5: request in the same clk as the registered lvbl fall
        wr_cnt = 0;
        push_copy(256);
        lvbl = 1'b0;
        @(negedge clk);
        dma_req = 1'b1;
        @(negedge clk);
        dma_req = 1'b0;
        chk("t5_start_same_clk", busy, 1);
        wait_done(n);
        chk("t5_done_latency", n, 257);
        chk("t5_write_count", wr_cnt, 256);
        lvbl = 1'b1;
        repeat (10) @(negedge clk);
        lvbl = 1'b0;
        watch(300, bn, dn);
        chk("t5_no_extra_copy", bn, 0);
        lvbl = 1'b1;
        repeat (10) @(negedge clk);

        // 6: reset at cnt=50 abandons the copy; next blank copies everything
        dma_en = 1'b1;
        wr_cnt = 0;
        push_copy(50);
        lvbl = 1'b0;
        wait_busy(n);
        repeat (50) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_busy_in_reset", busy, 0);
        chk("t6_we_in_reset", obj_we, 0);
        chk("t6_vram_addr_in_reset", vram_addr, 13'h0123);
        chk("t6_write_count", wr_cnt, 50);
        chk("t6_queue_empty", exp_q.size(), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        watch(5, bn, dn);
        chk("t6_no_start_mid_blank", bn, 0);
        lvbl = 1'b1;
        repeat (10) @(negedge clk);
        full_copy("t6", 2);
        lvbl = 1'b1;
        repeat (5) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
